wb_demux4: RTL and testbench
============================

Name: wb_demux4

Overview:
- 1-to-4 registered result router for the 24-bit CPU datapath; the writeback-side counterpart of the 4:1 operand-select mux.
- Takes one producer stream (ALU/memory result plus 2-bit destination select) and steers each word into one of four single-entry holding registers (dest 0: B, 1: counter, 2: immediate/offset, 3: address).
- Each destination has its own valid/ready handshake, so a stalled consumer blocks only its own lane.

Parameters:
- WIDTH, 24, data width of input and every output lane.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  router accepts the word this cycle.
- in_sel  input  2  destination lane 0..3.
- in_data  input  WIDTH  result word.
- out_data0  output  WIDTH  lane 0 holding register.
- out_data1  output  WIDTH  lane 1 holding register.
- out_data2  output  WIDTH  lane 2 holding register.
- out_data3  output  WIDTH  lane 3 holding register.
- out_valid  output  4  bit i set: lane i holds an undelivered word.
- out_ready  input  4  bit i set: consumer i takes lane i word this cycle.

Behaviour:
- One clock (clk); reset rst is synchronous, active-high. Sampled only on the rising clk edge.
- Reset: out_valid=4'b0000, out_data0..3=0, in_ready=0 while rst=1. A word presented in the same cycle as rst=1 is dropped.
- Lane state: each lane i is EMPTY (valid_i=0) or FULL (valid_i=1). No other state.
- in_ready (combinational, rst=0): in_ready = !valid[in_sel] || out_ready[in_sel].
  - Depends only on the selected lane; other lanes' state is irrelevant.
- Accept: in_valid && in_ready at an edge.
  - data[in_sel] <= in_data; valid[in_sel] <= 1.
  - Latency: exactly 1 cycle from accept to out_valid visible.
- Drain: valid_i && out_ready_i at an edge, with lane i not being written: valid_i <= 0.
  - out_data_i holds its last value; it is not cleared.
- Simultaneous drain and fill of the same lane: valid stays 1 and data takes the new word.
  - Sustained throughput is 1 word/cycle into a ready lane.
- A write to lane j never alters the data or valid of any lane k != j.
- out_ready_i while valid_i=0: ignored.
- Producer rule: while in_valid && !in_ready, in_sel and in_data must stay stable.
  - The router never accepts a word without in_ready=1, so no word is lost or duplicated.
- in_sel covers all four codes; there is no default or illegal lane.
- Reset mid-operation: all FULL lanes return to EMPTY with data zeroed on the reset edge; undelivered words are discarded.

Optional Feature:
- Macro: WB_DEMUX_STATS_EN.
- Defined:
  - Adds input stat_clr (1 bit) and output stat_cnt (32 bits, lane i count in bits [8i+7:8i]).
  - Each lane has an 8-bit counter, +1 on every accepted write to that lane.
  - Counters saturate at 255 and do not wrap.
  - rst or stat_clr zeroes all counters on the edge; stat_clr has priority over a same-cycle increment.
- Not defined: ports and counters are absent; routing behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0000, all out_data=0 after release; nothing captured.
- Single route: in_sel=2, in_data=24'hABCDEF, out_ready=0000 -> next cycle out_valid=0100, out_data2=ABCDEF, other lanes unchanged.
- Backpressure: lane 1 FULL (24'h000011), out_ready[1]=0, in_sel=1, in_data=24'h000022 -> in_ready=0; lane 1 stays 000011. Then out_ready[1]=1 -> accept; next cycle out_data1=000022, valid held.
- Lane isolation: lane 0 FULL and stalled, in_sel=3, data=24'h123456 -> in_ready=1; lane 3 gets 123456; lane 0 unchanged.
- Streaming: in_sel=0 with out_ready[0]=1 and data 1,2,3,4 on back-to-back cycles -> in_ready=1 every cycle; out_data0 = 1,2,3,4 one cycle later each; out_valid[0] stays 1.
- Stats (WB_DEMUX_STATS_EN): 300 writes to lane 1 -> stat_cnt[15:8]=255. stat_clr=1 -> all counters 0 next cycle.

Source files
------------

// File: rtl/wb_demux4.sv
// wb_demux4 -- 1-to-4 registered result router for the 24-bit CPU datapath.
// One producer stream is steered by in_sel into one of four single-entry
// holding registers (0: B, 1: counter, 2: immediate/offset, 3: address).
// Each lane has its own valid/ready handshake, so a stalled consumer only
// blocks writes aimed at its own lane.
//
// Optional build macro: WB_DEMUX_STATS_EN
//   Adds stat_clr / stat_cnt and one saturating 8-bit write counter per lane.
//   Routing behaviour is identical with or without it.
module wb_demux4 #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef WB_DEMUX_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_cnt
`endif
);

  logic [WIDTH-1:0] r_data [4];
  logic [3:0]       r_valid;
  logic             w_accept;
  logic [3:0]       w_wr;

  // Ready depends only on the selected lane: free now, or being drained this edge.
  always_comb begin
    in_ready = !rst && (!r_valid[in_sel] || out_ready[in_sel]);
  end

  // One-hot write strobe for the lane that accepts the producer word.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    w_wr     = 4'b0000;
    w_accept = in_valid && in_ready;
    if (w_accept) w_wr[in_sel] = 1'b1;
  end

  // Lane state: fill has priority over drain, so drain+fill keeps valid set.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every lane
    // sees pre-edge values regardless of statement order.
    if (rst) begin
      r_valid <= 4'b0000;
      // NOTE: the holding registers are cleared on reset because their
      // contents are visible on out_data*; a plain storage array would not be.
      for (int i = 0; i < 4; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr[i]) begin
          r_data[i]  <= in_data;
          r_valid[i] <= 1'b1;
        end else if (r_valid[i] && out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign out_valid = r_valid;

`ifdef WB_DEMUX_STATS_EN
  logic [7:0] r_cnt [4];

  // Per-lane saturating write counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr[i] && (r_cnt[i] != 8'hFF)) r_cnt[i] <= r_cnt[i] + 8'd1;
      end
    end
  end

  assign stat_cnt = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_wb_demux4.sv
// Self-checking bench for wb_demux4 (define WB_DEMUX_STATS_EN to cover the
// counter feature). A lane model predicts state; words pushed into per-lane
// scoreboard queues on accept are popped and compared when delivered.
module tb_wb_demux4;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [W-1:0] in_data;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         stat_clr;
  logic [31:0]  stat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  logic         m_valid [4];
  logic [W-1:0] m_data  [4];
  logic [W-1:0] sb      [4][$];
  logic [7:0]   m_cnt   [4];

  always #5 clk = ~clk;

  wb_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef WB_DEMUX_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  function automatic logic [W-1:0] lane_data(input int i);
    case (i)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_valid[i];
    return v;
  endfunction

  // One clock of stimulus with scoreboard bookkeeping around the edge.
  task automatic drive_cycle(input logic r, input logic v, input logic [1:0] sel,
                             input logic [W-1:0] d, input logic [3:0] ordy,
                             output logic rdy_seen);
    logic         exp_rdy, acc;
    logic [W-1:0] want, got;
    @(negedge clk);
    rst = r; in_valid = v; in_sel = sel; in_data = d; out_ready = ordy;
    #1;
    exp_rdy  = !r && (!m_valid[sel] || ordy[sel]);
    rdy_seen = in_ready;
    n_cmp++;
    if (in_ready !== exp_rdy) begin
      n_bad++;
      $display("FAIL in_ready sel=%0d: got %b expected %b", sel, in_ready, exp_rdy);
    end
    acc = v && exp_rdy;
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i] && ordy[i] && sb[i].size() > 0) begin
          want = sb[i].pop_front();
          got  = lane_data(i);
          n_cmp++;
          if (got !== want) begin
            n_bad++;
            $display("FAIL deliver lane%0d: got %h expected %h", i, got, want);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_valid[i] = 1'b0; m_data[i] = '0; sb[i].delete();
      end else if (acc && sel == 2'(i)) begin
        m_valid[i] = 1'b1; m_data[i] = d; sb[i].push_back(d);
      end else if (m_valid[i] && ordy[i]) begin
        m_valid[i] = 1'b0;
      end
`ifdef WB_DEMUX_STATS_EN
      if (r || stat_clr) m_cnt[i] = 8'd0;
      else if (acc && sel == 2'(i) && m_cnt[i] != 8'hFF) m_cnt[i] = m_cnt[i] + 8'd1;
`endif
    end
    n_cmp++;
    if (out_valid !== model_valid()) begin
      n_bad++;
      $display("FAIL out_valid: got %b expected %b", out_valid, model_valid());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (lane_data(i) !== m_data[i]) begin
        n_bad++;
        $display("FAIL out_data%0d: got %h expected %h", i, lane_data(i), m_data[i]);
      end
    end
`ifdef WB_DEMUX_STATS_EN
    n_cmp++;
    if (stat_cnt !== {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]}) begin
      n_bad++;
      $display("FAIL stat_cnt: got %h expected %h", stat_cnt,
               {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
    end
`endif
  endtask

  task automatic test_reset();
    logic rdy;
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, 1'b1, 2'd2, 24'h5A5A5A, 4'b0000, rdy);
      n_cmp++;
      if (rdy !== 1'b0) begin
        n_bad++; $display("FAIL reset_in_ready: got %b expected 0", rdy);
      end
    end
    drive_cycle(1'b0, 1'b0, 2'd0, '0, 4'b0000, rdy);
    n_cmp++;
    if (out_valid !== 4'b0000 || out_data2 !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b data2=%h expected 0000/000000", out_valid, out_data2);
    end
  endtask

  task automatic test_single_route();
    logic rdy;
    drive_cycle(1'b0, 1'b1, 2'd2, 24'hABCDEF, 4'b0000, rdy);
    n_cmp++;
    if (out_valid !== 4'b0100 || out_data2 !== 24'hABCDEF || out_data0 !== '0) begin
      n_bad++;
      $display("FAIL single_route: got valid=%b data2=%h expected 0100/abcdef", out_valid, out_data2);
    end
  endtask

  task automatic test_backpressure();
    logic rdy;
    drive_cycle(1'b0, 1'b1, 2'd1, 24'h000011, 4'b0000, rdy);
    drive_cycle(1'b0, 1'b1, 2'd1, 24'h000022, 4'b0000, rdy);
    n_cmp++;
    if (rdy !== 1'b0 || out_data1 !== 24'h000011) begin
      n_bad++;
      $display("FAIL backpressure_stall: got rdy=%b data1=%h expected 0/000011", rdy, out_data1);
    end
    drive_cycle(1'b0, 1'b1, 2'd1, 24'h000022, 4'b0010, rdy);
    n_cmp++;
    if (rdy !== 1'b1 || out_data1 !== 24'h000022 || out_valid[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: got rdy=%b data1=%h v1=%b expected 1/000022/1",
               rdy, out_data1, out_valid[1]);
    end
  endtask

  task automatic test_lane_isolation();
    logic rdy;
    drive_cycle(1'b0, 1'b0, 2'd0, '0, 4'b1111, rdy);          // drain all
    drive_cycle(1'b0, 1'b1, 2'd0, 24'h0000A0, 4'b0000, rdy);  // lane 0 full
    drive_cycle(1'b0, 1'b1, 2'd3, 24'h123456, 4'b0000, rdy);
    n_cmp++;
    if (rdy !== 1'b1 || out_data3 !== 24'h123456 || out_data0 !== 24'h0000A0 ||
        out_valid !== 4'b1001) begin
      n_bad++;
      $display("FAIL lane_isolation: got rdy=%b d3=%h d0=%h v=%b expected 1/123456/0000a0/1001",
               rdy, out_data3, out_data0, out_valid);
    end
  endtask

  task automatic test_streaming();
    logic rdy;
    for (int k = 1; k <= 4; k++) begin
      drive_cycle(1'b0, 1'b1, 2'd0, W'(k), 4'b0001, rdy);
      n_cmp++;
      if (rdy !== 1'b1 || out_data0 !== W'(k) || out_valid[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL streaming word %0d: got rdy=%b d0=%h v0=%b expected 1/%h/1",
                 k, rdy, out_data0, out_valid[0], W'(k));
      end
    end
    drive_cycle(1'b0, 1'b0, 2'd0, '0, 4'b1111, rdy);          // drain, data held
    n_cmp++;
    if (out_valid !== 4'b0000 || out_data0 !== W'(4)) begin
      n_bad++;
      $display("FAIL drain_hold: got v=%b d0=%h expected 0000/000004", out_valid, out_data0);
    end
  endtask

  task automatic test_mid_reset();
    logic rdy;
    drive_cycle(1'b0, 1'b1, 2'd1, 24'hBEEF01, 4'b0000, rdy);
    drive_cycle(1'b0, 1'b1, 2'd2, 24'hBEEF02, 4'b0000, rdy);
    drive_cycle(1'b1, 1'b1, 2'd3, 24'hBEEF03, 4'b0000, rdy);
    n_cmp++;
    if (out_valid !== 4'b0000 || out_data1 !== '0 || out_data3 !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b d1=%h d3=%h expected 0000/0/0", out_valid, out_data1, out_data3);
    end
  endtask

  task automatic test_random();
    logic rdy;
    for (int k = 0; k < 200; k++)
      drive_cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  W'($urandom), 4'($urandom_range(0, 15)), rdy);
    drive_cycle(1'b0, 1'b0, 2'd0, '0, 4'b1111, rdy);
  endtask

`ifdef WB_DEMUX_STATS_EN
  task automatic test_stats();
    logic rdy;
    stat_clr = 1'b1;
    drive_cycle(1'b0, 1'b0, 2'd0, '0, 4'b1111, rdy);
    stat_clr = 1'b0;
    for (int k = 0; k < 300; k++)
      drive_cycle(1'b0, 1'b1, 2'd1, W'(k), 4'b0010, rdy);
    n_cmp++;
    if (stat_cnt[15:8] !== 8'hFF) begin
      n_bad++; $display("FAIL stats_saturate: got %h expected ff", stat_cnt[15:8]);
    end
    stat_clr = 1'b1;
    drive_cycle(1'b0, 1'b1, 2'd1, 24'h777777, 4'b0010, rdy);
    stat_clr = 1'b0;
    n_cmp++;
    if (stat_cnt !== 32'h0) begin
      n_bad++; $display("FAIL stats_clear: got %h expected 00000000", stat_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0; stat_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_data[i] = '0; m_cnt[i] = 8'd0;
    end
    test_reset();
    test_single_route();
    test_backpressure();
    test_lane_isolation();
    test_streaming();
    test_mid_reset();
    test_random();
`ifdef WB_DEMUX_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
